// File: rtl/pattern_detect_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_detect_ctrl
//   Serial bit-pattern detector with a configure / run / done control flow.
//   A configuration handshake in IDLE latches a pattern (1..MAXLEN bits), the
//   overlap mode and a window length in bits. In RUN, each accepted serial bit
//   is shifted into a history register and compared against the pattern. A
//   detection produces a one-cycle match pulse and bumps a saturating counter.
//   The run ends after the programmed number of accepted bits (done pulse) or
//   on abort (no done pulse).
//
// Ports
//   clk          clock, all state updates on posedge
//   rst          asynchronous active-low reset
//   cfg_valid    configuration request
//   cfg_ready    configuration can be accepted (IDLE)
//   cfg_pattern  pattern bits, bit [cfg_len-1] is the first expected bit
//   cfg_len      pattern length, legal 1..MAXLEN
//   cfg_overlap  1 = overlapping detection, 0 = non-overlapping
//   cfg_nbits    run window in accepted bits, legal 1..65535
//   din_valid    serial bit offered
//   din          serial data bit
//   din_ready    serial bit accepted this cycle when din_valid is high
//   abort        terminates a run
//   match        one-cycle pulse per detection
//   match_count  detections in the current or last run (saturating)
//   busy         high while in RUN
//   done         one-cycle pulse at normal run completion
//   cfg_err      one-cycle pulse on a rejected configuration
// -----------------------------------------------------------------------------
module pattern_detect_ctrl #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned CNTW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [4:0]        cfg_len,
    input  logic              cfg_overlap,
    input  logic [15:0]       cfg_nbits,
    input  logic              din_valid,
    input  logic              din,
    output logic              din_ready,
    input  logic              abort,
    output logic              match,
    output logic [CNTW-1:0]   match_count,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [MAXLEN-1:0]   hist_q, hist_d;
    logic [MAXLEN-1:0]   pat_q, pat_d;
    logic [4:0]          len_q, len_d;
    logic                ovl_q, ovl_d;
    logic [4:0]          fill_q, fill_d;
    logic [15:0]         rem_q, rem_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic                match_q, match_d;
    logic                cfg_err_q, cfg_err_d;

    logic [MAXLEN-1:0]   hist_shift;
    logic [4:0]          fill_inc;
    logic                hit;
    logic                cfg_legal;

    // History after taking the current din, and whether that completes the
    // pattern. Only the low len_q bits of history take part in the compare.
    always_comb begin
        hist_shift = {hist_q[MAXLEN-2:0], din};
        fill_inc   = (fill_q == 5'(MAXLEN)) ? fill_q : fill_q + 5'd1;
        hit        = (fill_inc >= len_q);
        for (int unsigned i = 0; i < MAXLEN; i++) begin
            if ((5'(i) < len_q) && (hist_shift[i] != pat_q[i])) begin
                hit = 1'b0;
            end
        end
    end

    assign cfg_legal = (cfg_len != 5'd0) && (cfg_len <= 5'(MAXLEN)) &&
                       (cfg_nbits != 16'd0);

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        fill_d    = fill_q;
        rem_d     = rem_q;
        count_d   = count_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;

        cfg_ready = (state_q == S_IDLE);
        din_ready = (state_q == S_RUN) && !abort;
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);

        unique case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_legal) begin
                        pat_d   = cfg_pattern;
                        len_d   = cfg_len;
                        ovl_d   = cfg_overlap;
                        rem_d   = cfg_nbits;
                        hist_d  = '0;
                        fill_d  = '0;
                        count_d = '0;
                        state_d = S_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (din_valid) begin
                    hist_d = hist_shift;
                    fill_d = fill_inc;
                    rem_d  = rem_q - 16'd1;
                    if (hit) begin
                        match_d = 1'b1;
                        if (count_q != '1) begin
                            count_d = count_q + 1'b1;
                        end
                        // Non-overlapping: the next hit needs len fresh bits.
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                    end
                    if (rem_q == 16'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            hist_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            fill_q    <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            fill_q    <= fill_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pattern_detect_ctrl
//   Directed bench for pattern_detect_ctrl with hand-computed expectations.
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_pattern_detect_ctrl;

    localparam int unsigned MAXLEN = 8;
    localparam int unsigned CNTW   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [4:0]        cfg_len;
    logic              cfg_overlap;
    logic [15:0]       cfg_nbits;
    logic              din_valid;
    logic              din;
    logic              din_ready;
    logic              abort;
    logic              match;
    logic [CNTW-1:0]   match_count;
    logic              busy;
    logic              done;
    logic              cfg_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pattern_detect_ctrl #(
        .MAXLEN(MAXLEN),
        .CNTW  (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_nbits  (cfg_nbits),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .abort      (abort),
        .match      (match),
        .match_count(match_count),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [MAXLEN-1:0] pat, input logic [4:0] len,
                             input logic ovl, input logic [15:0] nb);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_nbits   = nb;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    // Offer one bit, then check the registered match pulse and the counter.
    task automatic send_bit(input string tag, input logic b, input logic exp_match,
                            input int exp_cnt);
        din_valid = 1'b1;
        din       = b;
        tick();
        din_valid = 1'b0;
        chk({tag, "_match"}, 32'(match), 32'(exp_match));
        chk({tag, "_cnt"}, 32'(match_count), 32'(exp_cnt));
    endtask

    initial begin
        rst         = 1'b0;
        cfg_valid   = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cfg_nbits   = '0;
        din_valid   = 1'b0;
        din         = 1'b0;
        abort       = 1'b0;

        // Reset values while rst is held low
        #12;
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_din_ready", 32'(din_ready), 32'd0);
        chk("rst_cnt", 32'(match_count), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b1;
        #4;  // now 1 unit after the edge at t=15

        // Overlapping detection, 1010 in 101010: hits after bits 4 and 6
        configure(8'b0000_1010, 5'd4, 1'b1, 16'd6);
        chk("ov_busy", 32'(busy), 32'd1);
        chk("ov_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("ov_din_ready", 32'(din_ready), 32'd1);
        send_bit("ov_b1", 1'b1, 1'b0, 0);
        send_bit("ov_b2", 1'b0, 1'b0, 0);
        send_bit("ov_b3", 1'b1, 1'b0, 0);
        send_bit("ov_b4", 1'b0, 1'b1, 1);
        send_bit("ov_b5", 1'b1, 1'b0, 1);
        chk("ov_done_early", 32'(done), 32'd0);
        send_bit("ov_b6", 1'b0, 1'b1, 2);
        chk("ov_done", 32'(done), 32'd1);
        chk("ov_done_din_ready", 32'(din_ready), 32'd0);
        tick();
        chk("ov_done_pulse_end", 32'(done), 32'd0);
        chk("ov_idle_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("ov_cnt_held", 32'(match_count), 32'd2);

        // Non-overlapping: single hit after bit 4
        configure(8'b0000_1010, 5'd4, 1'b0, 16'd6);
        chk("nov_cnt_cleared", 32'(match_count), 32'd0);
        send_bit("nov_b1", 1'b1, 1'b0, 0);
        send_bit("nov_b2", 1'b0, 1'b0, 0);
        send_bit("nov_b3", 1'b1, 1'b0, 0);
        send_bit("nov_b4", 1'b0, 1'b1, 1);
        send_bit("nov_b5", 1'b1, 1'b0, 1);
        send_bit("nov_b6", 1'b0, 1'b0, 1);
        chk("nov_done", 32'(done), 32'd1);
        tick();

        // Rejected configurations: len=0, len=MAXLEN+1, nbits=0
        configure(8'b0000_1010, 5'd0, 1'b1, 16'd6);
        chk("err0_pulse", 32'(cfg_err), 32'd1);
        chk("err0_busy", 32'(busy), 32'd0);
        chk("err0_cnt", 32'(match_count), 32'd1);
        tick();
        chk("err0_pulse_end", 32'(cfg_err), 32'd0);
        configure(8'b0000_1010, 5'd9, 1'b1, 16'd6);
        chk("err9_pulse", 32'(cfg_err), 32'd1);
        chk("err9_cfg_ready", 32'(cfg_ready), 32'd1);
        tick();
        chk("err9_pulse_end", 32'(cfg_err), 32'd0);
        configure(8'b0000_1010, 5'd4, 1'b1, 16'd0);
        chk("errnb_pulse", 32'(cfg_err), 32'd1);
        chk("errnb_busy", 32'(busy), 32'd0);
        chk("errnb_cnt", 32'(match_count), 32'd1);
        tick();
        chk("errnb_pulse_end", 32'(cfg_err), 32'd0);

        // Gapped stream: 1010101010 with din_valid low every other cycle
        configure(8'b0000_1010, 5'd4, 1'b1, 16'd10);
        for (int k = 1; k <= 10; k++) begin
            send_bit($sformatf("gap_b%0d", k), (k % 2 == 1), (k >= 4) && (k % 2 == 0),
                     (k < 4) ? 0 : (k / 2) - 1);
            if (k < 10) begin
                tick();
                chk($sformatf("gap_idle%0d_match", k), 32'(match), 32'd0);
                chk($sformatf("gap_idle%0d_busy", k), 32'(busy), 32'd1);
                chk($sformatf("gap_idle%0d_done", k), 32'(done), 32'd0);
            end
        end
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_cnt", 32'(match_count), 32'd4);
        tick();

        // Abort with din_valid after 3 bits; pattern 10 already hit once
        configure(8'b0000_0010, 5'd2, 1'b1, 16'd6);
        send_bit("ab_b1", 1'b1, 1'b0, 0);
        send_bit("ab_b2", 1'b0, 1'b1, 1);
        send_bit("ab_b3", 1'b1, 1'b0, 1);
        din_valid = 1'b1;
        din       = 1'b0;
        abort     = 1'b1;
        #1;
        chk("ab_din_ready", 32'(din_ready), 32'd0);
        tick();
        din_valid = 1'b0;
        abort     = 1'b0;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("ab_match", 32'(match), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_cnt", 32'(match_count), 32'd1);
        tick();
        chk("ab_done_later", 32'(done), 32'd0);

        // Abort in IDLE is ignored: config still accepted
        abort = 1'b1;
        configure(8'b0000_0010, 5'd2, 1'b1, 16'd4);
        abort = 1'b0;
        chk("abidle_busy", 32'(busy), 32'd1);
        send_bit("rs_b1", 1'b1, 1'b0, 0);
        send_bit("rs_b2", 1'b0, 1'b1, 1);

        // Asynchronous reset between edges mid-run
        #2;
        rst = 1'b0;
        #1;
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_match", 32'(match), 32'd0);
        chk("rs_cnt", 32'(match_count), 32'd0);
        chk("rs_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rs_din_ready", 32'(din_ready), 32'd0);
        chk("rs_done", 32'(done), 32'd0);
        tick();
        chk("rs_held_done", 32'(done), 32'd0);
        #3;
        rst = 1'b1;
        tick();
        chk("rs_post_idle", 32'(cfg_ready), 32'd1);

        // Fresh run after reset release: non-overlapping 1010 over 4 bits
        configure(8'b0000_1010, 5'd4, 1'b0, 16'd4);
        chk("pr_busy", 32'(busy), 32'd1);
        send_bit("pr_b1", 1'b1, 1'b0, 0);
        send_bit("pr_b2", 1'b0, 1'b0, 0);
        send_bit("pr_b3", 1'b1, 1'b0, 0);
        send_bit("pr_b4", 1'b0, 1'b1, 1);
        chk("pr_done", 32'(done), 32'd1);
        tick();
        chk("pr_idle", 32'(cfg_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
